// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the SAP-style microcode sequencer: opcodes, control-word bit
// positions, the idle control word and the T-step encoding.
package cpu_sequencer_pkg;

  localparam int unsigned CtrlW = 15;
  localparam int unsigned OpW   = 4;

  // T0..T5 are consecutive so the step register can simply increment.
  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StT5   = 3'd5,
    StHalt = 3'd7
  } step_e;

  localparam logic [OpW-1:0] OpNop = 4'h0;
  localparam logic [OpW-1:0] OpLda = 4'h1;
  localparam logic [OpW-1:0] OpAdd = 4'h2;
  localparam logic [OpW-1:0] OpSub = 4'h3;
  localparam logic [OpW-1:0] OpSta = 4'h4;
  localparam logic [OpW-1:0] OpLdi = 4'h5;
  localparam logic [OpW-1:0] OpJmp = 4'h6;
  localparam logic [OpW-1:0] OpJc  = 4'h7;
  localparam logic [OpW-1:0] OpJz  = 4'h8;
  localparam logic [OpW-1:0] OpOut = 4'hE;
  localparam logic [OpW-1:0] OpHlt = 4'hF;

  // Control word layout: {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
  localparam int unsigned BitCp   = 14;
  localparam int unsigned BitEp   = 13;
  localparam int unsigned BitLp   = 12;
  localparam int unsigned BitNLma = 11;
  localparam int unsigned BitNLmd = 10;
  localparam int unsigned BitNCe  = 9;
  localparam int unsigned BitNLr  = 8;
  localparam int unsigned BitNLi  = 7;
  localparam int unsigned BitNEi  = 6;
  localparam int unsigned BitNLa  = 5;
  localparam int unsigned BitEa   = 4;
  localparam int unsigned BitSub  = 3;
  localparam int unsigned BitEu   = 2;
  localparam int unsigned BitNLb  = 1;
  localparam int unsigned BitNLo  = 0;

  // Every active-low strobe high, every active-high strobe low.
  localparam logic [CtrlW-1:0] CtrlIdle = 15'h0FE3;

  // Number of bus drivers enabled by a control word (Ep, CE, Ei, Ea, Eu).
  function automatic logic [2:0] bus_drivers(input logic [CtrlW-1:0] c);
    return 3'(c[BitEp]) + 3'(!c[BitNCe]) + 3'(!c[BitNEi]) + 3'(c[BitEa]) + 3'(c[BitEu]);
  endfunction

endpackage

// File: rtl/cpu_sequencer_ucode_rom.sv
// Combinational microcode table.
//   step     : current T-step
//   opcode   : IR upper nibble (only looked at from T3 on)
//   cf, zf   : ALU flags, used only by JC/JZ in T3
//   ctrl_raw : ungated control word for this step
//   last     : this step is the final one of the instruction
module cpu_sequencer_ucode_rom
  import cpu_sequencer_pkg::*;
(
  input  step_e              step,
  input  logic [OpW-1:0]     opcode,
  input  logic               cf,
  input  logic               zf,
  output logic [CtrlW-1:0]   ctrl_raw,
  output logic               last
);

  always_comb begin
    ctrl_raw = CtrlIdle;
    last     = 1'b0;
    case (step)
      StT0: begin
        ctrl_raw[BitEp]   = 1'b1;
        ctrl_raw[BitNLma] = 1'b0;
      end
      StT1: ctrl_raw[BitCp] = 1'b1;
      StT2: begin
        ctrl_raw[BitNCe] = 1'b0;
        ctrl_raw[BitNLi] = 1'b0;
      end
      StT3: begin
        last = 1'b1;
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: begin
            last              = 1'b0;
            ctrl_raw[BitNEi]  = 1'b0;
            ctrl_raw[BitNLma] = 1'b0;
          end
          OpLdi: begin
            ctrl_raw[BitNEi] = 1'b0;
            ctrl_raw[BitNLa] = 1'b0;
          end
          OpJmp: begin
            ctrl_raw[BitNEi] = 1'b0;
            ctrl_raw[BitLp]  = 1'b1;
          end
          OpJc: if (cf) begin
            ctrl_raw[BitNEi] = 1'b0;
            ctrl_raw[BitLp]  = 1'b1;
          end
          OpJz: if (zf) begin
            ctrl_raw[BitNEi] = 1'b0;
            ctrl_raw[BitLp]  = 1'b1;
          end
          OpOut: begin
            ctrl_raw[BitEa]  = 1'b1;
            ctrl_raw[BitNLo] = 1'b0;
          end
          default: ; // NOP, HLT and unused opcodes: idle single step
        endcase
      end
      StT4: begin
        case (opcode)
          OpLda: begin
            last             = 1'b1;
            ctrl_raw[BitNCe] = 1'b0;
            ctrl_raw[BitNLa] = 1'b0;
          end
          OpAdd, OpSub: begin
            ctrl_raw[BitNCe] = 1'b0;
            ctrl_raw[BitNLb] = 1'b0;
          end
          OpSta: begin
            ctrl_raw[BitEa]   = 1'b1;
            ctrl_raw[BitNLmd] = 1'b0;
          end
          default: last = 1'b1; // opcode changed under us: fall back to fetch
        endcase
      end
      StT5: begin
        last = 1'b1;
        case (opcode)
          OpAdd: begin
            ctrl_raw[BitEu]  = 1'b1;
            ctrl_raw[BitNLa] = 1'b0;
          end
          OpSub: begin
            ctrl_raw[BitEu]  = 1'b1;
            ctrl_raw[BitSub] = 1'b1;
            ctrl_raw[BitNLa] = 1'b0;
          end
          OpSta: ctrl_raw[BitNLr] = 1'b0;
          default: ;
        endcase
      end
      default: ; // StHalt
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Microcode sequencer for the 8-bit SAP-style CPU.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 1 advances one micro-step per cycle, 0 stalls
//   opcode     : IR upper nibble, valid from T3
//   cf, zf     : registered ALU flags
//   ctrl       : control word {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
//   t_state    : 0..5 for T0..T5, 7 for HALT
//   instr_done : final step of the current instruction
//   halted     : sequencer is in HALT
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned CTRL_W = 15,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   opcode,
  input  logic              cf,
  input  logic              zf,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        t_state,
  output logic              instr_done,
  output logic              halted
);

  step_e            step_q;
  logic [CtrlW-1:0] ctrl_raw;
  logic             last;
  logic             in_halt;

  cpu_sequencer_ucode_rom u_rom (
    .step     (step_q),
    .opcode   (opcode),
    .cf       (cf),
    .zf       (zf),
    .ctrl_raw (ctrl_raw),
    .last     (last)
  );

  assign in_halt = (step_q == StHalt);

  // HALT is left only through rst; en=0 freezes the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= StT0;
    end else if (!in_halt && en) begin
      if (last) begin
        step_q <= (step_q == StT3 && opcode == OpHlt) ? StHalt : StT0;
      end else begin
        step_q <= step_e'(step_q + 3'd1);
      end
    end
  end

  // Gating keeps strobes from repeating while stalled and silences everything in reset/HALT.
  always_comb begin
    ctrl       = CtrlIdle;
    t_state    = 3'd0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      t_state = step_q;
      halted  = in_halt;
      if (en && !in_halt) begin
        ctrl       = ctrl_raw;
        instr_done = last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (bus_drivers(ctrl) <= 3'd1);
    end
  end

endmodule
